// File: rtl/digital_clock_if.sv
// Control/status bundle between the minutes/seconds counter and its users.
// The optional hours fields exist only when DIGITAL_CLOCK_HOURS_EN is defined.
interface digital_clock_if;
   logic       en;
   logic       load;
   logic [5:0] load_min;
   logic [5:0] load_sec;
   logic [5:0] sec;
   logic [5:0] min;
   logic       sec_wrap;
   logic       min_wrap;
`ifdef DIGITAL_CLOCK_HOURS_EN
   logic [4:0] load_hour;
   logic [4:0] hour;
   logic       hour_wrap;

   modport master (
      output en, load, load_min, load_sec, load_hour,
      input  sec, min, sec_wrap, min_wrap, hour, hour_wrap
   );

   modport slave (
      input  en, load, load_min, load_sec, load_hour,
      output sec, min, sec_wrap, min_wrap, hour, hour_wrap
   );
`else
   modport master (
      output en, load, load_min, load_sec,
      input  sec, min, sec_wrap, min_wrap
   );

   modport slave (
      input  en, load, load_min, load_sec,
      output sec, min, sec_wrap, min_wrap
   );
`endif
endinterface

// File: rtl/digital_clock.sv
// Free-running mm:ss timekeeper with prescaler, saturating preset and wrap pulses.
// Define DIGITAL_CLOCK_HOURS_EN to add a 0..23 hours counter with its own wrap pulse.
module digital_clock #(
   parameter int unsigned TICKS_PER_SEC = 1
) (
   input logic           clk,
   input logic           rst_n,
   digital_clock_if.slave bus
);

   localparam int unsigned PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);
   localparam logic [5:0] MAX_MS = 6'd59;

   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [5:0]         sec_q, sec_d;
   logic [5:0]         min_q, min_d;
   logic               secWrap_q, secWrap_d;
   logic               minWrap_q, minWrap_d;
   logic               tick;
   logic               minCarry;

   function automatic logic [5:0] sat59(input logic [5:0] v);
      return (v > MAX_MS) ? MAX_MS : v;
   endfunction

   assign tick     = bus.en && (presc_q == PRESC_LAST);
   assign minCarry = tick && (sec_q >= MAX_MS);

   // Load wins over counting regardless of en; wrap pulses only come from counting.
   always_comb begin
      presc_d   = presc_q;
      sec_d     = sec_q;
      min_d     = min_q;
      secWrap_d = 1'b0;
      minWrap_d = 1'b0;
      if (bus.load) begin
         presc_d = '0;
         sec_d   = sat59(bus.load_sec);
         min_d   = sat59(bus.load_min);
      end else if (bus.en) begin
         if (tick) begin
            presc_d = '0;
            if (minCarry) begin
               sec_d     = 6'd0;
               secWrap_d = 1'b1;
               if (min_q >= MAX_MS) begin
                  min_d     = 6'd0;
                  minWrap_d = 1'b1;
               end else begin
                  min_d = min_q + 6'd1;
               end
            end else begin
               sec_d = sec_q + 6'd1;
            end
         end else begin
            presc_d = presc_q + PRESC_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q   <= '0;
         sec_q     <= '0;
         min_q     <= '0;
         secWrap_q <= 1'b0;
         minWrap_q <= 1'b0;
      end else begin
         presc_q   <= presc_d;
         sec_q     <= sec_d;
         min_q     <= min_d;
         secWrap_q <= secWrap_d;
         minWrap_q <= minWrap_d;
      end
   end

   assign bus.sec      = sec_q;
   assign bus.min      = min_q;
   assign bus.sec_wrap = secWrap_q;
   assign bus.min_wrap = minWrap_q;

`ifdef DIGITAL_CLOCK_HOURS_EN
   localparam logic [4:0] MAX_HOUR = 5'd23;

   logic [4:0] hour_q, hour_d;
   logic       hourWrap_q, hourWrap_d;

   // Hours advance on the same edge that produces min_wrap, i.e. on the minute carry.
   always_comb begin
      hour_d     = hour_q;
      hourWrap_d = 1'b0;
      if (bus.load) begin
         hour_d = (bus.load_hour > MAX_HOUR) ? MAX_HOUR : bus.load_hour;
      end else if (minCarry && (min_q >= MAX_MS)) begin
         if (hour_q >= MAX_HOUR) begin
            hour_d     = 5'd0;
            hourWrap_d = 1'b1;
         end else begin
            hour_d = hour_q + 5'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hour_q     <= '0;
         hourWrap_q <= 1'b0;
      end else begin
         hour_q     <= hour_d;
         hourWrap_q <= hourWrap_d;
      end
   end

   assign bus.hour      = hour_q;
   assign bus.hour_wrap = hourWrap_q;
`endif

endmodule

// File: tb/tb_digital_clock.sv
// Bench for digital_clock: one instance at one tick per second, one with a divide-by-4 prescaler.
// Expected results are queued as stimulus is driven and compared just after each clock edge.
module tb_digital_clock;

   typedef struct {
      logic       en;
      logic       load;
      logic [5:0] lMin;
      logic [5:0] lSec;
      logic [5:0] eSec;
      logic [5:0] eMin;
      logic       eSecWrap;
      logic       eMinWrap;
   } vec_t;

   logic clk = 1'b0;
   logic rstA_n = 1'b0;
   logic rstB_n = 1'b0;
   int   checks = 0;
   int   passes = 0;
   vec_t expQ[$];

   digital_clock_if ifA ();
   digital_clock_if ifB ();

   digital_clock #(.TICKS_PER_SEC(1)) dutA (.clk(clk), .rst_n(rstA_n), .bus(ifA));
   digital_clock #(.TICKS_PER_SEC(4)) dutB (.clk(clk), .rst_n(rstB_n), .bus(ifB));

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic en, input logic load, input int lMin, input int lSec,
                               input int eSec, input int eMin, input logic sw, input logic mw);
      vec_t v;
      v.en = en; v.load = load; v.lMin = 6'(lMin); v.lSec = 6'(lSec);
      v.eSec = 6'(eSec); v.eMin = 6'(eMin); v.eSecWrap = sw; v.eMinWrap = mw;
      return v;
   endfunction

   task automatic checkOutput(input bit sel, input string name);
      vec_t e;
      logic [5:0] aSec, aMin;
      logic aSw, aMw;
      e = expQ.pop_front();
      if (sel) begin
         aSec = ifB.sec; aMin = ifB.min; aSw = ifB.sec_wrap; aMw = ifB.min_wrap;
      end else begin
         aSec = ifA.sec; aMin = ifA.min; aSw = ifA.sec_wrap; aMw = ifA.min_wrap;
      end
      checks++;
      if (aSec == e.eSec && aMin == e.eMin && aSw == e.eSecWrap && aMw == e.eMinWrap)
         passes++;
      else
         $display("[TB] FAIL %s: got min=%0d sec=%0d sw=%0b mw=%0b, want min=%0d sec=%0d sw=%0b mw=%0b",
                  name, aMin, aSec, aSw, aMw, e.eMin, e.eSec, e.eSecWrap, e.eMinWrap);
   endtask

   task automatic applyStimulus(input bit sel, input vec_t v, input string name);
      if (sel) begin
         ifB.en = v.en; ifB.load = v.load; ifB.load_min = v.lMin; ifB.load_sec = v.lSec;
      end else begin
         ifA.en = v.en; ifA.load = v.load; ifA.load_min = v.lMin; ifA.load_sec = v.lSec;
      end
      expQ.push_back(v);
      @(posedge clk);
      #1;
      checkOutput(sel, name);
   endtask

   task automatic checkDirect(input string name, input int got, input int want);
      checks++;
      if (got == want) passes++;
      else $display("[TB] FAIL %s: got %0d want %0d", name, got, want);
   endtask

   vec_t tableA[$];

   initial begin
      int e;
      ifA.en = 1'b1; ifA.load = 1'b0; ifA.load_min = '0; ifA.load_sec = '0;
      ifB.en = 1'b0; ifB.load = 1'b0; ifB.load_min = '0; ifB.load_sec = '0;
`ifdef DIGITAL_CLOCK_HOURS_EN
      ifA.load_hour = '0;
      ifB.load_hour = '0;
`endif

      // Load priority, saturation, enable hold, and a full 59:59 rollover.
      tableA.push_back(mk(1, 1, 63, 45, 45, 59, 0, 0));
      tableA.push_back(mk(1, 0,  0,  0, 46, 59, 0, 0));
      tableA.push_back(mk(0, 0,  0,  0, 46, 59, 0, 0));
      tableA.push_back(mk(1, 1, 59, 58, 58, 59, 0, 0));
      tableA.push_back(mk(1, 0,  0,  0, 59, 59, 0, 0));
      tableA.push_back(mk(1, 0,  0,  0,  0,  0, 1, 1));
      tableA.push_back(mk(1, 0,  0,  0,  1,  0, 0, 0));
      tableA.push_back(mk(0, 1, 10, 63, 59, 10, 0, 0));
      tableA.push_back(mk(1, 1,  0, 59, 59,  0, 0, 0));
      tableA.push_back(mk(1, 0,  0,  0,  0,  1, 1, 0));
      tableA.push_back(mk(0, 0,  0,  0,  0,  1, 0, 0));

      applyStimulus(0, mk(1, 0, 0, 0, 0, 0, 0, 0), "resetHold0");
      applyStimulus(0, mk(1, 0, 0, 0, 0, 0, 0, 0), "resetHold1");
      rstA_n = 1'b1;
      rstB_n = 1'b1;

      for (int c = 1; c <= 200; c++)
         applyStimulus(0, mk(1, 0, 0, 0, c % 60, c / 60, (c % 60) == 0, 0), $sformatf("carry%0d", c));
      checkDirect("carry200Min", int'(ifA.min), 3);
      checkDirect("carry200Sec", int'(ifA.sec), 20);

      for (int i = 0; i < tableA.size(); i++)
         applyStimulus(0, tableA[i], $sformatf("table%0d", i));

`ifdef DIGITAL_CLOCK_HOURS_EN
      ifA.load_hour = 5'd23;
      applyStimulus(0, mk(1, 1, 59, 59, 59, 59, 0, 0), "hourPreset");
      checkDirect("hourPresetVal", int'(ifA.hour), 23);
      ifA.load_hour = 5'd0;
      applyStimulus(0, mk(1, 0, 0, 0, 0, 0, 1, 1), "hourRoll");
      checkDirect("hourRollVal", int'(ifA.hour), 0);
      checkDirect("hourWrap", int'(ifA.hour_wrap), 1);
`endif

      // Asynchronous reset between edges must clear outputs before the next edge.
      applyStimulus(0, mk(1, 1, 63, 45, 45, 59, 0, 0), "asyncPreload");
      ifA.load = 1'b0;
      #2 rstA_n = 1'b0;
      #1;
      checkDirect("asyncResetSec", int'(ifA.sec), 0);
      checkDirect("asyncResetMin", int'(ifA.min), 0);
      ifA.en = 1'b0;
      @(posedge clk);
      #1 rstA_n = 1'b1;

      // Divide-by-4 instance: seconds follow the count of enabled edges only.
      e = 0;
      for (int k = 0; k < 19; k++) begin
         logic en;
         en = !(k >= 10 && k < 13);
         if (en) e++;
         applyStimulus(1, mk(en, 0, 0, 0, e / 4, 0, 0, 0), $sformatf("presc%0d", k));
      end
      applyStimulus(1, mk(1, 1, 5, 10, 10, 5, 0, 0), "prescLoad");
      for (int k = 1; k <= 4; k++)
         applyStimulus(1, mk(1, 0, 0, 0, (k == 4) ? 11 : 10, 5, 0, 0), $sformatf("prescResume%0d", k));

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/digital_clock.md
# digital_clock

Free-running minutes/seconds timekeeping counter. Advances a seconds count once every `TICKS_PER_SEC` enabled clock cycles and carries into minutes at 59→0. Sits beside the display/status logic as the single source of elapsed-time values. It supports a synchronous time preset and emits single-cycle wrap pulses for downstream alarm or scheduling logic.

## Interface
- `TICKS_PER_SEC`, default 1: enabled clock cycles per seconds increment; legal range 1..2^24; the prescaler width is $clog2(TICKS_PER_SEC) with a minimum of 1.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-low reset; assertion clears all state immediately; deassertion is synchronised by the system.
- `en`  input  1  count enable; when low, the prescaler and counters hold.
- `load`  input  1  synchronous preset strobe.
- `load_min`  input  6  minutes preset value.
- `load_sec`  input  6  seconds preset value.
- `sec`  output  6  seconds count, 0..59, registered.
- `min`  output  6  minutes count, 0..59, registered.
- `sec_wrap`  output  1  one-cycle pulse, registered, asserted in the cycle `sec` becomes 0 by counting from 59.
- `min_wrap`  output  1  one-cycle pulse, registered, asserted in the cycle `min` becomes 0 by counting from 59.

## Operation
- Prescaler counts enabled cycles from 0 to TICKS_PER_SEC-1. Reaching the terminal value produces a "tick" and returns the prescaler to 0.
- When TICKS_PER_SEC=1, every enabled cycle is a tick.
- On a tick:
  - `sec` increments.
  - When `sec`=59, `sec` goes to 0, `sec_wrap` asserts, and `min` increments.
  - When `min`=59 at that same wrap, `min` goes to 0 and `min_wrap` asserts.
- Load has priority over counting and does not depend on `en`:
  - `sec`←min(`load_sec`,59) and `min`←min(`load_min`,59). Out-of-range preset values saturate to 59.
  - The prescaler clears.
  - `sec_wrap` and `min_wrap` are 0 in the load cycle.
- While `en`=0 and `load`=0, all state holds and both wrap pulses are 0.
- Counters never hold values above 59.

## Timing
- Reset values: `sec`=0, `min`=0, `sec_wrap`=0, `min_wrap`=0, prescaler=0 (hours=0 when configured).
- Reset asserted mid-count clears all state asynchronously. It has priority over `load` and `en`.
- Latency from tick to output is one edge: with TICKS_PER_SEC=1 and `en`=1, `sec` reads 1 after the first rising edge following reset release.
- A load applied at edge N is visible after edge N. Counting resumes from the preset at edge N+1, with the first tick TICKS_PER_SEC enabled edges later.
- Wrap pulses are high for exactly one cycle and are coincident with the 0 value of the wrapped counter.
- No combinational path from any input to any output.

## Configuration
- `DIGITAL_CLOCK_HOURS_EN` defined:
  - Adds output `hour` (5 bits, 0..23, reset 0) and input `load_hour` (5 bits, saturates to 23).
  - `hour` increments when `min_wrap` occurs and wraps 23→0.
  - Adds a one-cycle output `hour_wrap`, asserted in the cycle `hour` returns to 0 by counting.
- `DIGITAL_CLOCK_HOURS_EN` undefined: these ports and their logic are absent, and `min` simply wraps 59→0.

## Test plan
- Reset: drive `rst`=0 for 2 cycles with `en`=1. Require `sec`=0 and `min`=0 throughout. Release reset, then require `sec`=1,2,3… on successive edges (TICKS_PER_SEC=1).
- Carry: run 200 cycles from reset with `en`=1 (TICKS_PER_SEC=1).
  - `sec` wraps 59→0 at cycle 60, with `sec_wrap`=1 for that single cycle and `min`=1.
  - At cycle 200, require `min`=3 and `sec`=20.
- Full rollover: load `min`=59, `sec`=58, then run 2 ticks. Require 59:59, then 00:00 with `sec_wrap`=1 and `min_wrap`=1 in the same cycle.
- Enable/prescaler: build with TICKS_PER_SEC=4. Require `sec` to advance every 4th edge. Drop `en` for 3 cycles and require `sec` and the prescaler to freeze, with the count resuming afterwards.
- Load priority and saturation: pulse `load` with `load_min`=63, `load_sec`=45 while `en`=1 → 59:45. Assert `rst` low asynchronously between edges → outputs become 0 before the next edge.
- Hours (with `DIGITAL_CLOCK_HOURS_EN`): preset 23:59:59 and apply one tick → 0:00:00 with `hour_wrap`=1.
